armleocpu_regfile_mp: RTL and testbench

Parametrised multi-read-port register file for ArmleoCPU, the successor to the fixed two-read-port, 32x32 register file. It provides NUM_READ synchronous read ports, one write port, a hardwired zero register, optional write-to-read bypass, and a post-reset clear sequencer. The sequencer zeroes the whole array, so the storage can map onto reset-less RAM. It sits between decode (read) and writeback (write) in the core pipeline.

---
 rtl/armleocpu_regfile_mp.sv | 104 ++++++++++
 tb/tb_armleocpu_regfile_mp.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_regfile_mp.sv
// rtl/armleocpu_regfile_mp.sv - multi-read-port register file with zero register, bypass and clear sweep

module armleocpu_regfile_mp #(
    parameter int NUM_READ   = 2,
    parameter int ELEMENTS_W = 5,
    parameter int WIDTH      = 32,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             ready,
    input  logic [NUM_READ-1:0]              rs_read,
    input  logic [NUM_READ*ELEMENTS_W-1:0]   rs_addr,
    output logic [NUM_READ*WIDTH-1:0]        rs_rdata,
    input  logic                             rd_write,
    input  logic [ELEMENTS_W-1:0]            rd_addr,
    input  logic [WIDTH-1:0]                 rd_wdata
);

    localparam int DEPTH = 1 << ELEMENTS_W;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [ELEMENTS_W-1:0]        cnt_q, cnt_d;
    logic [NUM_READ*WIDTH-1:0]    rdata_q, rdata_d;

    // Storage carries no reset so it can map onto plain RAM; the sweep zeroes it.
    logic [WIDTH-1:0]             mem_q [DEPTH];

    logic                         mem_we;
    logic [ELEMENTS_W-1:0]        mem_waddr;
    logic [WIDTH-1:0]             mem_wdata;

    assign ready    = (state_q == RUN);
    assign rs_rdata = rdata_q;

    // Control state and read-data registers; reset forces the sweep to restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Single write port into the array, shared by the clear sweep and normal writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Next state, write port steering and per-port read data selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = rd_addr;
        mem_wdata = rd_wdata;
        rdata_d   = rdata_q;

        case (state_q)
            CLEAR: begin
                // Sweep owns the write port; user writes and reads are ignored.
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + ELEMENTS_W'(1);
                if (cnt_q == {ELEMENTS_W{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                mem_we = rd_write && (rd_addr != '0);
                for (int i = 0; i < NUM_READ; i++) begin
                    if (rs_read[i]) begin
                        if (rs_addr[i*ELEMENTS_W +: ELEMENTS_W] == '0) begin
                            // Entry 0 is never trusted from storage.
                            rdata_d[i*WIDTH +: WIDTH] = '0;
                        end else if ((BYPASS != 0) && rd_write &&
                                     (rd_addr == rs_addr[i*ELEMENTS_W +: ELEMENTS_W])) begin
                            rdata_d[i*WIDTH +: WIDTH] = rd_wdata;
                        end else begin
                            rdata_d[i*WIDTH +: WIDTH] = mem_q[rs_addr[i*ELEMENTS_W +: ELEMENTS_W]];
                        end
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_armleocpu_regfile_mp.sv
// tb/tb_armleocpu_regfile_mp.sv - directed vector bench for armleocpu_regfile_mp

module tb_armleocpu_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the default (bypass) and the no-bypass instances
    logic        rst_n;
    logic [1:0]  rs_read;
    logic [9:0]  rs_addr;
    logic        rd_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        a_ready, b_ready;
    logic [63:0] a_rdata, b_rdata;

    // Wide instance: 4 ports, 16 entries, 64-bit data
    logic         c_rst_n;
    logic [3:0]   c_rs_read;
    logic [15:0]  c_rs_addr;
    logic         c_rd_write;
    logic [3:0]   c_rd_addr;
    logic [63:0]  c_rd_wdata;
    logic         c_ready;
    logic [255:0] c_rdata;

    armleocpu_regfile_mp #(.NUM_READ(2), .ELEMENTS_W(5), .WIDTH(32), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ready(a_ready),
        .rs_read(rs_read), .rs_addr(rs_addr), .rs_rdata(a_rdata),
        .rd_write(rd_write), .rd_addr(rd_addr), .rd_wdata(rd_wdata)
    );

    armleocpu_regfile_mp #(.NUM_READ(2), .ELEMENTS_W(5), .WIDTH(32), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ready(b_ready),
        .rs_read(rs_read), .rs_addr(rs_addr), .rs_rdata(b_rdata),
        .rd_write(rd_write), .rd_addr(rd_addr), .rd_wdata(rd_wdata)
    );

    armleocpu_regfile_mp #(.NUM_READ(4), .ELEMENTS_W(4), .WIDTH(64), .BYPASS(1)) dut_c (
        .clk(clk), .rst_n(c_rst_n), .ready(c_ready),
        .rs_read(c_rs_read), .rs_addr(c_rs_addr), .rs_rdata(c_rdata),
        .rd_write(c_rd_write), .rd_addr(c_rd_addr), .rd_wdata(c_rd_wdata)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  rd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ea0;
        logic [31:0] ea1;
        logic [31:0] eb0;
        logic [31:0] eb1;
    } vec_t;

    vec_t vecs [17];

    initial begin
        // we wa wd rd ra0 ra1 | bypass p0 p1 | no-bypass p0 p1
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd0, 32'h12345678, 2'b00, 5'd0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 5'd0, 32'h12345678, 2'b11, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[5]  = '{1'b1, 5'd7, 32'h11111111, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[6]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 2'b11, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11111111, 32'h11111111};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        2'b01, 5'd7, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11111111};
        vecs[8]  = '{1'b1, 5'd3, 32'h3,        2'b10, 5'd0, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        2'b01, 5'd3, 5'd0, 32'h3, 32'hDEADBEEF, 32'h3, 32'hDEADBEEF};
        vecs[10] = '{1'b1, 5'd3, 32'h4,        2'b10, 5'd3, 5'd3, 32'h3, 32'h4, 32'h3, 32'h3};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        2'b00, 5'd3, 5'd3, 32'h3, 32'h4, 32'h3, 32'h3};
        vecs[12] = '{1'b0, 5'd0, 32'h0,        2'b10, 5'd3, 5'd3, 32'h3, 32'h4, 32'h3, 32'h4};
        vecs[13] = '{1'b0, 5'd0, 32'h0,        2'b00, 5'd3, 5'd3, 32'h3, 32'h4, 32'h3, 32'h4};
        vecs[14] = '{1'b0, 5'd0, 32'h0,        2'b00, 5'd3, 5'd3, 32'h3, 32'h4, 32'h3, 32'h4};
        vecs[15] = '{1'b1, 5'd9, 32'h99,       2'b01, 5'd31, 5'd0, 32'h0, 32'h4, 32'h0, 32'h4};
        vecs[16] = '{1'b0, 5'd0, 32'h0,        2'b10, 5'd0, 5'd9, 32'h0, 32'h99, 32'h0, 32'h99};

        rst_n = 1'b0; rs_read = '0; rs_addr = '0; rd_write = 1'b0; rd_addr = '0; rd_wdata = '0;
        c_rst_n = 1'b0; c_rs_read = '0; c_rs_addr = '0; c_rd_write = 1'b0; c_rd_addr = '0; c_rd_wdata = '0;
        step();
        step();
        check("reset_ready_a", {255'b0, a_ready}, 256'd0);
        check("reset_rdata_a", {192'b0, a_rdata}, 256'd0);
        check("reset_rdata_b", {192'b0, b_rdata}, 256'd0);

        // Partial sweep interrupted at edge 10; user traffic must be ignored
        rst_n = 1'b1;
        rs_read = 2'b11; rs_addr = {5'd5, 5'd5};
        rd_write = 1'b1; rd_addr = 5'd5; rd_wdata = 32'hFFFFFFFF;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("midsweep_ready", {255'b0, a_ready}, 256'd0);
            check("midsweep_rdata", {192'b0, a_rdata}, 256'd0);
        end
        rst_n = 1'b0;
        #1;
        check("midsweep_rst_ready", {254'b0, a_ready, b_ready}, 256'd0);
        check("midsweep_rst_rdata", {128'b0, a_rdata, b_rdata}, 256'd0);
        step();

        // Full sweep: ready only after edge 32
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            check($sformatf("sweep_ready_e%0d", k), {254'b0, a_ready, b_ready},
                  (k == 32) ? 256'd3 : 256'd0);
            if (k < 32) check("sweep_rdata_zero", {192'b0, a_rdata}, 256'd0);
        end
        rd_write = 1'b0; rs_read = 2'b00;

        // Every entry reads back zero on port 0
        for (int k = 0; k < 32; k++) begin
            rs_read = 2'b01; rs_addr = {5'd0, 5'(k)};
            step();
            check($sformatf("cleared_x%0d", k), {224'b0, a_rdata[31:0]}, 256'd0);
        end

        for (int v = 0; v < 17; v++) begin
            rd_write = vecs[v].we; rd_addr = vecs[v].wa; rd_wdata = vecs[v].wd;
            rs_read = vecs[v].rd; rs_addr = {vecs[v].ra1, vecs[v].ra0};
            step();
            check($sformatf("vec%0d_a", v), {192'b0, a_rdata}, {192'b0, vecs[v].ea1, vecs[v].ea0});
            check($sformatf("vec%0d_b", v), {192'b0, b_rdata}, {192'b0, vecs[v].eb1, vecs[v].eb0});
        end
        rd_write = 1'b0; rs_read = 2'b00;

        // Reset mid-run: outputs drop without a clock edge, sweep repeats, x9 lost
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_ready", {254'b0, a_ready, b_ready}, 256'd0);
        check("midrun_rst_rdata", {128'b0, a_rdata, b_rdata}, 256'd0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            check($sformatf("resweep_ready_e%0d", k), {255'b0, a_ready}, (k == 32) ? 256'd1 : 256'd0);
        end
        rs_read = 2'b11; rs_addr = {5'd9, 5'd9};
        step();
        check("x9_after_reset_a", {192'b0, a_rdata}, 256'd0);
        check("x9_after_reset_b", {192'b0, b_rdata}, 256'd0);
        rs_read = 2'b00;

        // Wide instance: 16-edge sweep
        c_rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("c_sweep_ready_e%0d", k), {255'b0, c_ready}, (k == 16) ? 256'd1 : 256'd0);
        end
        c_rd_write = 1'b1; c_rd_addr = 4'd9; c_rd_wdata = 64'h0123456789ABCDEF;
        c_rs_read = 4'b1000; c_rs_addr = {4'd9, 4'd0, 4'd0, 4'd0};
        step();
        check("c_bypass_p3", c_rdata, {64'h0123456789ABCDEF, 192'b0});
        c_rd_write = 1'b0;
        c_rs_read = 4'b1111; c_rs_addr = {4'd15, 4'd9, 4'd0, 4'd9};
        step();
        check("c_read4", c_rdata, {64'h0, 64'h0123456789ABCDEF, 64'h0, 64'h0123456789ABCDEF});
        c_rs_read = 4'b0000;
        #2;
        c_rst_n = 1'b0;
        #1;
        check("c_rst_rdata", c_rdata, 256'd0);
        check("c_rst_ready", {255'b0, c_ready}, 256'd0);
        step();
        c_rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("c_resweep_e%0d", k), {255'b0, c_ready}, (k == 16) ? 256'd1 : 256'd0);
        end
        c_rs_read = 4'b0001; c_rs_addr = {4'd0, 4'd0, 4'd0, 4'd9};
        step();
        check("c_x9_cleared", c_rdata, 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
